instruction_decoder: RTL
========================

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have parameter: SQUASH_CYCLES, 2, number of fetched instructions discarded after a taken jump (legal 0..3).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: sync_reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port: pm_data  input  8  instruction word from synchronous program memory, valid for the address issued the previous cycle.
REQ-005 SHALL have port: alu_zero  input  1  ALU result-is-zero, valid in the same cycle as alu_en.
REQ-006 SHALL have port: jmp  output  1  unconditional jump request to the program sequencer.
REQ-007 SHALL have port: jmp_nz  output  1  jump-if-not-zero request to the program sequencer.
REQ-008 SHALL have port: jmp_addr  output  4  jump target high nibble (target = {jmp_addr,4'h0}).
REQ-009 SHALL have port: dont_jmp  output  1  registered zero flag; suppresses jmp_nz in the sequencer.
REQ-010 SHALL have port: ld_en  output  1  register-load enable.
REQ-011 SHALL have port: ld_sel  output  3  destination register select.
REQ-012 SHALL have port: imm  output  4  immediate data for loads.
REQ-013 SHALL have port: alu_en  output  1  ALU operation enable.
REQ-014 SHALL have port: alu_func  output  3  ALU function code.
REQ-015 SHALL have port: from_ID  output  8  debug copy of the instruction register.

Function
REQ-016 SHALL hold an 8-bit instruction register ir; NOP encoding is 8'hE0.
REQ-017 SHALL decode ir combinationally: 0ddd_iiii = load (ld_en=1, ld_sel=ir[6:4], imm=ir[3:0]); 10ff_fxxx = ALU (alu_en=1, alu_func=ir[5:3]); 1100_aaaa = jmp; 1101_aaaa = jmp_nz; 111x_xxxx = NOP.
REQ-018 SHALL drive jmp_addr=ir[3:0] for jmp/jmp_nz and 4'h0 otherwise; ld_sel, imm, alu_func SHALL be 0 when their enable is low.
REQ-019 SHALL assert at most one of ld_en, alu_en, jmp, jmp_nz in any cycle.
REQ-020 SHALL hold a zero flag z, loaded with alu_zero on any rising edge where alu_en=1, otherwise held; dont_jmp = z.
REQ-021 SHALL give jmp_nz in the cycle immediately after an ALU op the updated z (no bubble needed).
REQ-022 SHALL treat a jump as taken when jmp=1, or jmp_nz=1 and z=0.
REQ-023 SHALL implement a two-state FSM RUN/SQUASH with a 2-bit squash counter cnt.
REQ-024 In RUN: ir<=pm_data each edge; on a taken jump with SQUASH_CYCLES>0, cnt<=SQUASH_CYCLES and go to SQUASH.
REQ-025 In SQUASH: ir<=NOP, cnt<=cnt-1; return to RUN on the edge where cnt==1.
REQ-026 SHALL with SQUASH_CYCLES=0 never enter SQUASH; taken jumps only pass through.
REQ-027 SHALL not re-trigger squash from a NOP loaded during SQUASH; a not-taken jmp_nz SHALL cause no squash.
REQ-028 SHALL drive from_ID=ir at all times.

Reset
REQ-029 SHALL on sync_reset=1 at an edge set ir=NOP, z=0, cnt=0, state=RUN, regardless of current state (including mid-SQUASH).
REQ-030 SHALL after reset output jmp=0, jmp_nz=0, jmp_addr=0, dont_jmp=0, ld_en=0, alu_en=0, ld_sel=0, imm=0, alu_func=0, from_ID=8'hE0.
REQ-031 SHALL have sync_reset take priority over every other update in the same cycle.

Verification
REQ-032 SHALL verify load: pm_data=8'h5A after reset -> next cycle ld_en=1, ld_sel=3'd5, imm=4'hA, all jump outputs 0.
REQ-033 SHALL verify flag: ALU op 8'h88 with alu_zero=1, then 8'hD3 -> jmp_nz=1, jmp_addr=4'h3, dont_jmp=1, no squash; following pm_data loaded directly.
REQ-034 SHALL verify taken jump: 8'hC7 with SQUASH_CYCLES=2 -> jmp=1, jmp_addr=4'h7 for one cycle, next two cycles from_ID=8'hE0 despite pm_data=8'h11, third cycle from_ID=pm_data.
REQ-035 SHALL verify taken jmp_nz: ALU with alu_zero=0, then 8'hD9 -> dont_jmp=0, jmp_nz=1, two squashed cycles follow.
REQ-036 SHALL verify reset mid-SQUASH: sync_reset=1 one cycle after a taken jump -> next cycle state RUN, from_ID=8'hE0, z=0, following pm_data=8'h23 loaded on the next edge.
REQ-037 SHALL verify SQUASH_CYCLES=0: 8'hC2 then 8'h31 -> jmp=1 one cycle, next cycle ld_en=1, ld_sel=3'd3, imm=4'h1.

Source files
------------

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - 8-bit instruction decoder with zero flag and post-jump squash
module instruction_decoder #(
   parameter int SQUASH_CYCLES = 2
) (
   input  logic       clk,
   input  logic       sync_reset,
   input  logic [7:0] pm_data,
   input  logic       alu_zero,
   output logic       jmp,
   output logic       jmp_nz,
   output logic [3:0] jmp_addr,
   output logic       dont_jmp,
   output logic       ld_en,
   output logic [2:0] ld_sel,
   output logic [3:0] imm,
   output logic       alu_en,
   output logic [2:0] alu_func,
   output logic [7:0] from_ID
);

   localparam logic [7:0] NOP    = 8'hE0;
   localparam logic [1:0] SQ_LEN = 2'(SQUASH_CYCLES);
   localparam bit         SQ_EN  = (SQUASH_CYCLES > 0);

   typedef enum logic {RUN, SQUASH} state_t;

   state_t     state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic [7:0] ir, ir_nxt;
   logic       z, z_nxt;
   logic       taken;

   always_comb begin
      jmp      = 1'b0;
      jmp_nz   = 1'b0;
      jmp_addr = 4'h0;
      ld_en    = 1'b0;
      ld_sel   = 3'd0;
      imm      = 4'h0;
      alu_en   = 1'b0;
      alu_func = 3'd0;
      if (!ir[7]) begin
         ld_en  = 1'b1;
         ld_sel = ir[6:4];
         imm    = ir[3:0];
      end else if (!ir[6]) begin
         alu_en   = 1'b1;
         alu_func = ir[5:3];
      end else if (!ir[5]) begin
         jmp      = !ir[4];
         jmp_nz   = ir[4];
         jmp_addr = ir[3:0];
      end
   end

   assign dont_jmp = z;
   assign from_ID  = ir;
   assign taken    = jmp | (jmp_nz & ~z);

   // cnt counts squash NOPs still to be shown; the cnt==1 edge already accepts the next fetch
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ir_nxt    = pm_data;
      z_nxt     = alu_en ? alu_zero : z;
      case (state)
         RUN: begin
            if (taken && SQ_EN) begin
               ir_nxt    = NOP;
               cnt_nxt   = SQ_LEN;
               state_nxt = SQUASH;
            end
         end
         SQUASH: begin
            cnt_nxt = cnt - 2'd1;
            if (cnt == 2'd1) state_nxt = RUN;
            else             ir_nxt    = NOP;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state <= RUN;
         cnt   <= 2'd0;
         ir    <= NOP;
         z     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ir    <= ir_nxt;
         z     <= z_nxt;
      end
   end

endmodule
